// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register slave.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } spi_state_e;

  localparam int unsigned DefNumRegs    = 5;
  localparam int unsigned DefDataW      = 8;
  localparam int unsigned DefAddrW      = 7;
  localparam int unsigned DefSyncStages = 2;

  localparam int unsigned REG_EN_OUT_7_0  = 0;
  localparam int unsigned REG_EN_OUT_15_8 = 1;
  localparam int unsigned REG_EN_PWM_7_0  = 2;
  localparam int unsigned REG_EN_PWM_15_8 = 3;
  localparam int unsigned REG_PWM_DUTY    = 4;

  function automatic int unsigned frame_width(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous input with rise/fall detection on the synced level.
module spi_sync_edge #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      prev_q <= sync_q[Stages-1];
    end
  end

  assign rise_o = sync_q[Stages-1] & ~prev_q;
  assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave in the clk domain; read-back on cipo is enabled by
// defining SPI_REG_SLAVE_READBACK_EN.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS    = DefNumRegs,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 err_cnt
);

  localparam int unsigned FrameW = frame_width(ADDR_W, DATA_W);
  localparam int unsigned CntW   = $clog2(FrameW + 1);
  localparam logic [CntW-1:0]   LastBit  = CntW'(FrameW - 1);
  localparam logic [ADDR_W:0]   NumRegsA = (ADDR_W + 1)'(NUM_REGS);

  logic [SYNC_STAGES-1:0] copi_sync_q, ncs_sync_q;
  logic copi_s, ncs_s, sclk_rise, sclk_fall;

  // ncs resets to its idle (deselected) level so the FSM cannot start a phantom frame
  always_ff @(posedge clk) begin
    if (rst) begin
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
    end else begin
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
    end
  end

  assign copi_s = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

  spi_sync_edge #(
    .Stages(SYNC_STAGES)
  ) u_sclk_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (sclk),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  spi_state_e                 state_q;
  logic [CntW-1:0]            cnt_q;
  logic [FrameW-2:0]          sr_q;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_wr;
  logic                       wr_strobe_q;
  logic [ADDR_W-1:0]          wr_addr_q;
  logic [7:0]                 err_cnt_q;

  logic [FrameW-1:0] frame;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [DATA_W-1:0] wr_data;
  logic              wr_hit;

  // Full frame as it would stand once the current copi bit is captured
  always_comb begin
    frame     = {sr_q, copi_s};
    wr_addr_c = frame[FrameW-2 -: ADDR_W];
    wr_data   = frame[DATA_W-1:0];
    wr_hit    = frame[FrameW-1] && ({1'b0, wr_addr_c} < NumRegsA);
    regs_wr   = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_addr_c == ADDR_W'(i)) regs_wr[i*DATA_W +: DATA_W] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sr_q        <= '0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!ncs_s) begin
            state_q <= StShift;
            cnt_q   <= '0;
          end
        end
        StShift: begin
          if (ncs_s) begin
            if (cnt_q != '0 && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            state_q <= StIdle;
          end else if (sclk_rise) begin
            sr_q  <= frame[FrameW-2:0];
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == LastBit) begin
              state_q <= StDone;
              if (wr_hit) begin
                regs_q      <= regs_wr;
                wr_strobe_q <= 1'b1;
                wr_addr_q   <= wr_addr_c;
              end
            end
          end
        end
        StDone: begin
          if (ncs_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign regs_flat = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign err_cnt   = err_cnt_q;

`ifdef SPI_REG_SLAVE_READBACK_EN
  localparam logic [CntW-1:0] AddrEnd   = CntW'(ADDR_W);
  localparam logic [CntW-1:0] DataStart = CntW'(ADDR_W + 1);

  logic              rd_rw;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_q;
  logic              oe_q;

  always_comb begin
    rd_rw   = sr_q[ADDR_W-1];
    rd_addr = {sr_q[ADDR_W-2:0], copi_s};
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = regs_q[i*DATA_W +: DATA_W];
    end
  end

  // The fall right after the load must not shift: the MSB is sampled on the next rise
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      oe_q  <= 1'b0;
    end else if (ncs_s) begin
      out_q <= '0;
      oe_q  <= 1'b0;
    end else if (state_q == StShift && sclk_rise && cnt_q == AddrEnd && !rd_rw) begin
      out_q <= rd_data;
      oe_q  <= 1'b1;
    end else if (oe_q && sclk_fall && cnt_q > DataStart) begin
      out_q <= {out_q[DATA_W-2:0], 1'b0};
    end
  end

  assign cipo    = oe_q & out_q[DATA_W-1];
  assign cipo_oe = oe_q;
`else
  logic unused_fall;
  assign unused_fall = sclk_fall;
  assign cipo        = 1'b0;
  assign cipo_oe     = 1'b0;
`endif

endmodule
